// File: rtl/input_debounce_pkg.sv
// Shared constants and counter-width helpers for the input_debounce block.
package input_debounce_pkg;

  localparam int N_SW  = 4;
  localparam int N_BTN = 4;

  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // Width that holds 0..n-1; never below one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width that holds 0..max(d,p)-1 for the shared repeat counter.
  function automatic int rpt_w(input int d, input int p);
    int m;
    m = (d > p) ? d : p;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/input_debounce_chan.sv
// One debounce channel: 2-flop synchronizer, stability counter, clean level, edge pulses.
// INPUT_DEBOUNCE_AUTOREPEAT_EN adds the fall_evt port used to cancel repeats.
module debounce_chan
  import input_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
  ,
  output logic fall_evt
`endif
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;
  logic          done;

  // clean flips on this edge
  assign done = (s2 != clean) && (cnt == CNT_MAX);

`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
  assign fall_evt = done && clean;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      clean <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= done && !clean;
      fall <= done && clean;
      if (s2 == clean) begin
        cnt <= '0;
      end else if (done) begin
        clean <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/input_debounce.sv
// Debounces 4 switches and 4 buttons; x = {sw_clean, btn_clean}.
// INPUT_DEBOUNCE_AUTOREPEAT_EN enables button autorepeat on btn_press.
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             system1000,
  input  logic             system1000_rst,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [7:0]       x,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  logic [N_SW-1:0]  sw_clean;
  logic [N_SW-1:0]  sw_rise_unused, sw_fall_unused;
  logic [N_BTN-1:0] btn_clean, btn_rise, btn_fall;
`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
  logic [N_SW-1:0]  sw_fevt_unused;
  logic [N_BTN-1:0] btn_fevt;
`endif

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan (
      .clk     (system1000),
      .rst     (system1000_rst),
      .raw     (sw_raw[i]),
      .clean   (sw_clean[i]),
      .rise    (sw_rise_unused[i]),
      .fall    (sw_fall_unused[i])
`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
      ,
      .fall_evt(sw_fevt_unused[i])
`endif
    );
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan (
      .clk     (system1000),
      .rst     (system1000_rst),
      .raw     (btn_raw[i]),
      .clean   (btn_clean[i]),
      .rise    (btn_rise[i]),
      .fall    (btn_fall[i])
`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
      ,
      .fall_evt(btn_fevt[i])
`endif
    );
  end

  assign x           = {sw_clean, btn_clean};
  assign btn_release = btn_fall;

`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
  localparam int RW = rpt_w(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [RW-1:0] DLY_MAX = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_MAX = RW'(REPEAT_PERIOD - 1);

  logic [N_BTN-1:0][RW-1:0] rpt_cnt;
  logic [N_BTN-1:0]         rpt_arm;
  logic [N_BTN-1:0]         rpt_pulse;

  // rpt_arm selects the period once the initial delay has elapsed
  for (genvar b = 0; b < N_BTN; b++) begin : g_rpt
    always_ff @(posedge system1000) begin
      if (system1000_rst || !btn_clean[b] || btn_fevt[b]) begin
        rpt_cnt[b]   <= '0;
        rpt_arm[b]   <= 1'b0;
        rpt_pulse[b] <= 1'b0;
      end else if (rpt_cnt[b] == (rpt_arm[b] ? PER_MAX : DLY_MAX)) begin
        rpt_cnt[b]   <= '0;
        rpt_arm[b]   <= 1'b1;
        rpt_pulse[b] <= 1'b1;
      end else begin
        rpt_cnt[b]   <= rpt_cnt[b] + RW'(1);
        rpt_pulse[b] <= 1'b0;
      end
    end
  end

  assign btn_press = btn_rise | rpt_pulse;
`else
  localparam int RPT_CFG_UNUSED = REPEAT_DELAY + REPEAT_PERIOD;
  assign btn_press = btn_rise;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_input_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw_raw, btn_raw;
  logic [7:0] x;
  logic [3:0] btn_press, btn_release;

  int n_chk = 0;
  int n_bad = 0;

  input_debounce #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .system1000    (clk),
    .system1000_rst(rst),
    .sw_raw        (sw_raw),
    .btn_raw       (btn_raw),
    .x             (x),
    .btn_press     (btn_press),
    .btn_release   (btn_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance n rising edges, land 1 time unit after the last
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic       quiet;
    logic       exp_p;
    bit         ar;
`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
    ar = 1'b1;
`else
    ar = 1'b0;
`endif
    rst = 1'b1; sw_raw = 4'h0; btn_raw = 4'h0;
    tick(2);
    sw_raw = 4'hF; btn_raw = 4'hF;
    tick(3);
    chk("rst_x", x, 8'h00);
    chk("rst_press", btn_press, 4'h0);
    chk("rst_release", btn_release, 4'h0);
    sw_raw = 4'h0; btn_raw = 4'h0;
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("idle_x", x, 8'h00);

    // single button rise, then fall
    btn_raw = 4'h1;
    tick(5);
    chk("b0_pre_x", x, 8'h00);
    chk("b0_pre_press", btn_press, 4'h0);
    tick(1);
    chk("b0_x", x, 8'h01);
    chk("b0_press", btn_press, 4'h1);
    tick(1);
    chk("b0_press_off", btn_press, 4'h0);
    chk("b0_hold_x", x, 8'h01);
    btn_raw = 4'h0;
    tick(5);
    chk("b0_rel_pre", x, 8'h01);
    tick(1);
    chk("b0_rel_x", x, 8'h00);
    chk("b0_release", btn_release, 4'h1);
    chk("b0_rel_press", btn_press, 4'h0);
    tick(1);
    chk("b0_release_off", btn_release, 4'h0);

    // 3-cycle glitch must be rejected
    btn_raw = 4'h2;
    tick(3);
    btn_raw = 4'h0;
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (x != 8'h00 || btn_press != 4'h0 || btn_release != 4'h0) quiet = 1'b0;
    end
    chk("glitch_quiet", quiet, 1'b1);

    // simultaneous switch and button transitions
    sw_raw = 4'hA; btn_raw = 4'h5;
    tick(5);
    chk("multi_pre_x", x, 8'h00);
    tick(1);
    chk("multi_x", x, 8'hA5);
    chk("multi_press", btn_press, 4'h5);
    tick(1);
    chk("multi_press_off", btn_press, 4'h0);
    sw_raw = 4'h0; btn_raw = 4'h0;
    tick(6);
    chk("multi_rel_x", x, 8'h00);
    chk("multi_release", btn_release, 4'h5);
    chk("multi_rel_press", btn_press, 4'h0);
    tick(1);
    chk("multi_release_off", btn_release, 4'h0);

    // reset on edge 4 of a pending rise discards it; raw still high restarts
    btn_raw = 4'h8;
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("midrst_x", x, 8'h00);
    chk("midrst_press", btn_press, 4'h0);
    chk("midrst_release", btn_release, 4'h0);
    rst = 1'b0;
    tick(5);
    chk("midrst_pre_x", x, 8'h00);
    chk("midrst_pre_press", btn_press, 4'h0);
    tick(1);
    chk("midrst_done_x", x, 8'h08);
    chk("midrst_done_press", btn_press, 4'h8);
    btn_raw = 4'h0;
    tick(6);
    chk("midrst_release", btn_release, 4'h8);
    tick(1);

    // hold button 2: repeats at +10,+13,+16,+19 when enabled; the one due
    // at +22 coincides with release and must be suppressed
    btn_raw = 4'h4;
    tick(6);
    chk("hold_press", btn_press, 4'h4);
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      exp_p = ar && (i >= 10) && (i <= 19) && ((i - 10) % 3 == 0);
      chk($sformatf("rpt_press@%0d", i), btn_press[2], exp_p);
      chk($sformatf("rpt_release@%0d", i), btn_release[2], (i == 22));
      if (i == 16) btn_raw = 4'h0;
    end
    chk("end_x", x, 8'h00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: stable-sample count before a clean level changes; legal range >= 2.
REQ-002 Parameter REPEAT_DELAY, default 25000000: held-button cycles before the first autorepeat pulse; used only with AUTOREPEAT_EN.
REQ-003 Parameter REPEAT_PERIOD, default 5000000: cycles between later autorepeat pulses; used only with AUTOREPEAT_EN.
REQ-004 Port system1000, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port system1000_rst, input, 1: reset, synchronous, active-high.
REQ-006 Port sw_raw, input, 4: asynchronous board switches.
REQ-007 Port btn_raw, input, 4: asynchronous board buttons.
REQ-008 Port x, output, 8: debounced levels packed as {sw_clean[3:0], btn_clean[3:0]}.
REQ-009 Port btn_press, output, 4: one-cycle pulse per debounced button rise, plus autorepeat pulses.
REQ-010 Port btn_release, output, 4: one-cycle pulse per debounced button fall.

Function
REQ-011 Each of the 8 channels SHALL pass its raw bit through a 2-flop synchronizer (s1, s2) before any other use.
REQ-012 Per channel, on each edge where s2 != clean: if cnt == DEBOUNCE_CYCLES-1, clean <= s2 and cnt <= 0; otherwise cnt <= cnt+1.
REQ-013 Per channel, on each edge where s2 == clean, cnt SHALL be 0.
REQ-014 Latency: counting the edge that first samples a new stable raw value as edge 1, clean SHALL update on edge 2+DEBOUNCE_CYCLES.
REQ-015 A raw excursion that keeps s2 != clean for fewer than DEBOUNCE_CYCLES edges SHALL leave clean unchanged and cnt at 0 afterwards.
REQ-016 btn_press[i] SHALL go high on the same edge btn_clean[i] goes 0->1, and stay high for exactly one cycle.
REQ-017 btn_release[i] SHALL go high on the same edge btn_clean[i] goes 1->0, and stay high for exactly one cycle.
REQ-018 All outputs SHALL be registered; no combinational path from raw inputs to outputs.
REQ-019 Channels SHALL be fully independent; simultaneous transitions on any subset SHALL each resolve per REQ-012..017.
REQ-020 cnt width SHALL be clog2(DEBOUNCE_CYCLES); cnt SHALL never exceed DEBOUNCE_CYCLES-1 or wrap.

Reset
REQ-021 While system1000_rst is high at an edge, s1, s2, clean, cnt, repeat state, x, btn_press and btn_release SHALL all become 0.
REQ-022 Reset asserted mid-count SHALL discard the count; no pulse SHALL be emitted for that transition.
REQ-023 A raw input already high when reset is released SHALL produce clean = 1 and, for buttons, one btn_press after 2+DEBOUNCE_CYCLES edges.

Configuration
REQ-024 Macro INPUT_DEBOUNCE_AUTOREPEAT_EN SHALL control autorepeat.
REQ-025 With the macro defined, for a button held clean high: an extra btn_press pulse SHALL occur REPEAT_DELAY cycles after the initial press pulse, then every REPEAT_PERIOD cycles.
REQ-026 With the macro defined, a debounced release SHALL stop repeats immediately; no repeat pulse SHALL coincide with btn_release.
REQ-027 With the macro undefined, btn_press SHALL pulse exactly once per debounced rise; no repeat counters SHALL be synthesized.
REQ-028 Switches SHALL never autorepeat.

Structure
REQ-029 Package input_debounce_pkg SHALL hold N_SW=4, N_BTN=4, the default parameter values and the counter-width function.
REQ-030 Sub-module debounce_chan (synchronizer, counter, clean register, edge pulses) SHALL be instantiated 8 times.
REQ-031 The autorepeat logic SHALL live in input_debounce, one repeat counter per button.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-032 btn_raw[0] 0->1 held -> btn_clean[0] and btn_press[0] rise on edge 6; btn_press[0] low on edge 7.
REQ-033 btn_raw[1] high for 3 cycles only -> x unchanged; no btn_press or btn_release pulse.
REQ-034 sw_raw=4'hA and btn_raw=4'h5 applied together -> x=8'hA5 on edge 6; btn_press=4'h5 for one cycle.
REQ-035 Reset pulsed on edge 4 of a pending transition -> all outputs 0; transition completes 2+4 edges after reset is released.
REQ-036 AUTOREPEAT_EN, btn_raw[2] held -> btn_press[2] pulses at press+10, +13, +16; release -> btn_release[2] pulse, no further presses.
REQ-037 Macro undefined, same hold -> exactly one btn_press[2] pulse.
